display_scheduler: RTL and testbench

Frame-synchronous scheduler for the 8-digit multiplexed 7-segment display on the Nexys4 DDR. It shares the display between a background client A (e.g. the countdown timer, always eligible) and a priority client B (alerts/messages, request/grant with minimum hold time). It generates the digit scan with an anti-ghosting blank interval and drives the 4-bit nibble into the existing `decoder_7_seg`. Ownership changes only on frame boundaries, so a frame never mixes sources.

---
 rtl/display_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_display_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// Frame-synchronous owner arbitration and digit scan for the 8-digit 7-segment display.
// Optional blank interval at each slot start is compiled in when DISPLAY_SCHED_BLANK_EN is defined.
module display_scheduler #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned HOLD_FRAMES  = 250
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [31:0] A_DATA,
    input  logic [7:0]  A_EN,
    input  logic        B_REQ,
    input  logic [31:0] B_DATA,
    input  logic [7:0]  B_EN,
    output logic        B_GNT,
    output logic        OWNER,
    output logic [3:0]  DIGIT_DATA,
    output logic [7:0]  DIGIT,
    output logic        FRAME_TICK
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);
    localparam logic [HW-1:0] HOLD_M1  = HW'(HOLD_FRAMES - 1);
`ifdef DISPLAY_SCHED_BLANK_EN
    localparam logic [PW-1:0] BLANK_START = PW'(BLANK_CYCLES);
`endif

    typedef enum logic [1:0] {
        IDLE_A  = 2'd0,
        PEND_B  = 2'd1,
        OWN_B   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    logic [PW-1:0] pre_r;
    logic [PW-1:0] pre_nxt_s;
    logic [2:0]    slot_r;
    logic [2:0]    slot_nxt_s;
    logic          boundary_s;
    state_t        state_r;
    state_t        state_nxt_s;
    logic [HW-1:0] hold_r;
    logic [HW-1:0] hold_nxt_s;
    logic          hold_done_s;
    logic          owner_nxt_s;
    logic [31:0]   sel_data_s;
    logic [7:0]    sel_en_s;
    logic          lit_s;
    logic [7:0]    digit_nxt_s;
    logic [3:0]    nib_nxt_s;
    logic          tick_nxt_s;
    logic          gnt_r;
    logic [3:0]    nib_r;
    logic [7:0]    digit_r;
    logic          tick_r;

    // Prescaler and slot index advance.
    always_comb begin
        pre_nxt_s  = pre_r;
        slot_nxt_s = slot_r;
        if (pre_r == PRE_LAST) begin
            pre_nxt_s  = '0;
            slot_nxt_s = slot_r + 3'd1;
        end else begin
            pre_nxt_s  = pre_r + PW'(1);
            slot_nxt_s = slot_r;
        end
    end

    assign boundary_s = (pre_r == PRE_LAST) && (slot_r == 3'd7);

    // Hold is judged against the count this boundary would produce, so B
    // is released after exactly HOLD_FRAMES owned frames.
    assign hold_done_s = (hold_r == HOLD_MAX) || (boundary_s && (hold_r == HOLD_M1));

    // Ownership next-state and hold counter.
    always_comb begin
        state_nxt_s = state_r;
        hold_nxt_s  = hold_r;
        case (state_r)
            IDLE_A: begin
                if (B_REQ && boundary_s) begin
                    state_nxt_s = OWN_B;
                    hold_nxt_s  = '0;
                end else if (B_REQ) begin
                    state_nxt_s = PEND_B;
                end else begin
                    state_nxt_s = IDLE_A;
                end
            end
            PEND_B: begin
                if (boundary_s) begin
                    state_nxt_s = OWN_B;
                    hold_nxt_s  = '0;
                end else begin
                    state_nxt_s = PEND_B;
                end
            end
            OWN_B: begin
                if (boundary_s && (hold_r != HOLD_MAX)) begin
                    hold_nxt_s = hold_r + HW'(1);
                end else begin
                    hold_nxt_s = hold_r;
                end
                if (!B_REQ && hold_done_s) begin
                    state_nxt_s = boundary_s ? IDLE_A : RELEASE;
                end else begin
                    state_nxt_s = OWN_B;
                end
            end
            RELEASE: begin
                if (B_REQ) begin
                    state_nxt_s = OWN_B;
                end else if (boundary_s) begin
                    state_nxt_s = IDLE_A;
                end else begin
                    state_nxt_s = RELEASE;
                end
            end
            default: begin
                state_nxt_s = IDLE_A;
                hold_nxt_s  = '0;
            end
        endcase
    end

    // Output values are built from next-cycle counters so the registered
    // outputs line up with the counter/state values of the same cycle.
    always_comb begin
        owner_nxt_s = (state_nxt_s == OWN_B) || (state_nxt_s == RELEASE);
        sel_data_s  = owner_nxt_s ? B_DATA : A_DATA;
        sel_en_s    = owner_nxt_s ? B_EN : A_EN;
        nib_nxt_s   = sel_data_s[{slot_nxt_s, 2'b00} +: 4];
`ifdef DISPLAY_SCHED_BLANK_EN
        lit_s       = sel_en_s[slot_nxt_s] && (pre_nxt_s >= BLANK_START);
`else
        lit_s       = sel_en_s[slot_nxt_s];
`endif
        digit_nxt_s = lit_s ? ~(8'd1 << slot_nxt_s) : 8'hFF;
        tick_nxt_s  = (pre_nxt_s == PRE_LAST) && (slot_nxt_s == 3'd7);
    end

    // Counter and ownership state registers.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            pre_r   <= '0;
            slot_r  <= 3'd0;
            state_r <= IDLE_A;
            hold_r  <= '0;
        end else begin
            pre_r   <= pre_nxt_s;
            slot_r  <= slot_nxt_s;
            state_r <= state_nxt_s;
            hold_r  <= hold_nxt_s;
        end
    end

    // Registered display outputs.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            gnt_r   <= 1'b0;
            nib_r   <= 4'h0;
            digit_r <= 8'hFF;
            tick_r  <= 1'b0;
        end else begin
            gnt_r   <= owner_nxt_s;
            nib_r   <= nib_nxt_s;
            digit_r <= digit_nxt_s;
            tick_r  <= tick_nxt_s;
        end
    end

    assign B_GNT      = gnt_r;
    assign OWNER      = gnt_r;
    assign DIGIT_DATA = nib_r;
    assign DIGIT      = digit_r;
    assign FRAME_TICK = tick_r;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: scan sequence, B arbitration, hold/release and async reset.
module tb_display_scheduler;

    localparam int SCAN_DIV     = 10;
    localparam int BLANK_CYCLES = 2;
    localparam int HOLD_FRAMES  = 3;
`ifdef DISPLAY_SCHED_BLANK_EN
    localparam int EXP_BLANK = 2;
`else
    localparam int EXP_BLANK = 0;
`endif
    localparam logic [31:0] A_PAT = 32'h76543210;
    localparam logic [31:0] B_PAT = 32'hFEDCBA98;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic [31:0] A_DATA = A_PAT;
    logic [7:0]  A_EN = 8'hFF;
    logic        B_REQ = 1'b0;
    logic [31:0] B_DATA = B_PAT;
    logic [7:0]  B_EN = 8'hFF;
    logic        B_GNT;
    logic        OWNER;
    logic [3:0]  DIGIT_DATA;
    logic [7:0]  DIGIT;
    logic        FRAME_TICK;

    int cyc = 0;
    int vectors = 0;
    int errors = 0;

    display_scheduler #(
        .SCAN_DIV(SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .HOLD_FRAMES(HOLD_FRAMES)
    ) dut (
        .CLK(CLK),
        .RESETN(RESETN),
        .A_DATA(A_DATA),
        .A_EN(A_EN),
        .B_REQ(B_REQ),
        .B_DATA(B_DATA),
        .B_EN(B_EN),
        .B_GNT(B_GNT),
        .OWNER(OWNER),
        .DIGIT_DATA(DIGIT_DATA),
        .DIGIT(DIGIT),
        .FRAME_TICK(FRAME_TICK)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] exp_digit(input int c, input logic [7:0] en);
        int p;
        int s;
        p = c % SCAN_DIV;
        s = (c / SCAN_DIV) % 8;
        if (en[s] && (p >= EXP_BLANK)) exp_digit = ~(8'h01 << s);
        else exp_digit = 8'hFF;
    endfunction

    function automatic logic [3:0] exp_nib(input int c, input logic [31:0] d);
        int s;
        s = (c / SCAN_DIV) % 8;
        exp_nib = d[4*s +: 4];
    endfunction

    function automatic logic exp_tick(input int c);
        exp_tick = ((c % (8 * SCAN_DIV)) == (8 * SCAN_DIV - 1));
    endfunction

    task automatic step();
        @(negedge CLK);
        cyc++;
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        repeat (3) @(negedge CLK);
        vectors += 5;
        if (DIGIT !== 8'hFF) begin errors++; $display("FAIL reset_digit: got %h want ff", DIGIT); end
        if (DIGIT_DATA !== 4'h0) begin errors++; $display("FAIL reset_data: got %h want 0", DIGIT_DATA); end
        if (B_GNT !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", B_GNT); end
        if (OWNER !== 1'b0) begin errors++; $display("FAIL reset_owner: got %b want 0", OWNER); end
        if (FRAME_TICK !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", FRAME_TICK); end
        RESETN = 1'b1;
        cyc = 0;
    endtask

    task automatic test_scan();
        while (cyc < 160) begin
            step();
            vectors += 4;
            if (DIGIT !== exp_digit(cyc, 8'hFF)) begin errors++; $display("FAIL scan_digit c=%0d: got %h want %h", cyc, DIGIT, exp_digit(cyc, 8'hFF)); end
            if (DIGIT_DATA !== exp_nib(cyc, A_PAT)) begin errors++; $display("FAIL scan_data c=%0d: got %h want %h", cyc, DIGIT_DATA, exp_nib(cyc, A_PAT)); end
            if (FRAME_TICK !== exp_tick(cyc)) begin errors++; $display("FAIL scan_tick c=%0d: got %b want %b", cyc, FRAME_TICK, exp_tick(cyc)); end
            if (B_GNT !== 1'b0) begin errors++; $display("FAIL scan_gnt c=%0d: got %b want 0", cyc, B_GNT); end
        end
    endtask

    task automatic test_pulse();
        logic own;
        while (cyc < 195) step();
        B_REQ = 1'b1;
        step();
        B_REQ = 1'b0;
        while (cyc < 483) begin
            own = (cyc >= 240) && (cyc < 480);
            vectors += 4;
            if (OWNER !== own) begin errors++; $display("FAIL pulse_owner c=%0d: got %b want %b", cyc, OWNER, own); end
            if (B_GNT !== own) begin errors++; $display("FAIL pulse_gnt c=%0d: got %b want %b", cyc, B_GNT, own); end
            if (DIGIT_DATA !== exp_nib(cyc, own ? B_PAT : A_PAT)) begin errors++; $display("FAIL pulse_data c=%0d: got %h want %h", cyc, DIGIT_DATA, exp_nib(cyc, own ? B_PAT : A_PAT)); end
            if (DIGIT !== exp_digit(cyc, 8'hFF)) begin errors++; $display("FAIL pulse_digit c=%0d: got %h want %h", cyc, DIGIT, exp_digit(cyc, 8'hFF)); end
            step();
        end
    endtask

    task automatic test_held();
        logic own;
        while (cyc < 485) step();
        B_REQ = 1'b1;
        while (cyc < 1452) begin
            if (cyc == 1405) B_REQ = 1'b0;
            own = (cyc >= 560) && (cyc < 1440);
            vectors += 2;
            if (OWNER !== own) begin errors++; $display("FAIL held_owner c=%0d: got %b want %b", cyc, OWNER, own); end
            if (DIGIT_DATA !== exp_nib(cyc, own ? B_PAT : A_PAT)) begin errors++; $display("FAIL held_data c=%0d: got %h want %h", cyc, DIGIT_DATA, exp_nib(cyc, own ? B_PAT : A_PAT)); end
            step();
        end
    endtask

    task automatic test_rerelease();
        logic own;
        while (cyc < 1445) step();
        B_REQ = 1'b1;
        while (cyc < 1932) begin
            if (cyc == 1770) B_REQ = 1'b0;
            if (cyc == 1800) B_REQ = 1'b1;
            if (cyc == 1900) B_REQ = 1'b0;
            own = (cyc >= 1520) && (cyc < 1920);
            vectors += 2;
            if (B_GNT !== own) begin errors++; $display("FAIL rerel_gnt c=%0d: got %b want %b", cyc, B_GNT, own); end
            if (DIGIT_DATA !== exp_nib(cyc, own ? B_PAT : A_PAT)) begin errors++; $display("FAIL rerel_data c=%0d: got %h want %h", cyc, DIGIT_DATA, exp_nib(cyc, own ? B_PAT : A_PAT)); end
            step();
        end
    endtask

    task automatic test_a_en();
        while (cyc < 1999) step();
        A_EN = 8'b0000_0101;
        step();
        while (cyc < 2160) begin
            vectors += 2;
            if (DIGIT !== exp_digit(cyc, 8'h05)) begin errors++; $display("FAIL aen_digit c=%0d: got %h want %h", cyc, DIGIT, exp_digit(cyc, 8'h05)); end
            if ((DIGIT | 8'b0000_0101) !== 8'hFF) begin errors++; $display("FAIL aen_mask c=%0d: got %h want only bits 0/2 low", cyc, DIGIT); end
            step();
        end
        A_EN = 8'hFF;
    endtask

    task automatic test_boundary_req();
        logic own;
        while (cyc < 2239) step();
        B_REQ = 1'b1;
        vectors++;
        if (OWNER !== 1'b0) begin errors++; $display("FAIL bnd_pre_owner c=%0d: got %b want 0", cyc, OWNER); end
        step();
        B_REQ = 1'b0;
        while (cyc < 2482) begin
            own = (cyc >= 2240) && (cyc < 2480);
            vectors += 2;
            if (OWNER !== own) begin errors++; $display("FAIL bnd_owner c=%0d: got %b want %b", cyc, OWNER, own); end
            if (DIGIT_DATA !== exp_nib(cyc, own ? B_PAT : A_PAT)) begin errors++; $display("FAIL bnd_data c=%0d: got %h want %h", cyc, DIGIT_DATA, exp_nib(cyc, own ? B_PAT : A_PAT)); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        while (cyc < 2500) step();
        B_REQ = 1'b1;
        step();
        B_REQ = 1'b0;
        while (cyc < 2605) step();
        vectors++;
        if (OWNER !== 1'b1) begin errors++; $display("FAIL mid_owner_before c=%0d: got %b want 1", cyc, OWNER); end
        RESETN = 1'b0;
        #1;
        vectors += 5;
        if (DIGIT !== 8'hFF) begin errors++; $display("FAIL mid_digit: got %h want ff", DIGIT); end
        if (DIGIT_DATA !== 4'h0) begin errors++; $display("FAIL mid_data: got %h want 0", DIGIT_DATA); end
        if (B_GNT !== 1'b0) begin errors++; $display("FAIL mid_gnt: got %b want 0", B_GNT); end
        if (OWNER !== 1'b0) begin errors++; $display("FAIL mid_owner: got %b want 0", OWNER); end
        if (FRAME_TICK !== 1'b0) begin errors++; $display("FAIL mid_tick: got %b want 0", FRAME_TICK); end
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        cyc = 0;
        // Leave a request pending, then reset before the boundary that would grant it.
        while (cyc < 20) step();
        B_REQ = 1'b1;
        step();
        B_REQ = 1'b0;
        while (cyc < 30) step();
        RESETN = 1'b0;
        #1;
        vectors++;
        if (DIGIT !== 8'hFF) begin errors++; $display("FAIL pend_rst_digit: got %h want ff", DIGIT); end
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        cyc = 0;
        while (cyc < 170) begin
            step();
            vectors += 4;
            if (OWNER !== 1'b0) begin errors++; $display("FAIL pend_owner c=%0d: got %b want 0", cyc, OWNER); end
            if (DIGIT !== exp_digit(cyc, 8'hFF)) begin errors++; $display("FAIL pend_digit c=%0d: got %h want %h", cyc, DIGIT, exp_digit(cyc, 8'hFF)); end
            if (DIGIT_DATA !== exp_nib(cyc, A_PAT)) begin errors++; $display("FAIL pend_data c=%0d: got %h want %h", cyc, DIGIT_DATA, exp_nib(cyc, A_PAT)); end
            if (FRAME_TICK !== exp_tick(cyc)) begin errors++; $display("FAIL pend_tick c=%0d: got %b want %b", cyc, FRAME_TICK, exp_tick(cyc)); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_pulse();
        test_held();
        test_rerelease();
        test_a_en();
        test_boundary_req();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
